// File: rtl/tft_pkg.sv
// Shared state encoding, command opcodes and word-formatting helper for the
// TFT frame sequencer and its command emitter.
package tft_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR,
        ST_FETCH,
        ST_LATCH,
        ST_SEND,
        ST_DONE,
        ST_GAP
    } state_t;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // Command and parameter bytes travel in the low byte of the 24-bit word.
    function automatic logic [23:0] byte_word(input logic [7:0] b);
        return {16'h0000, b};
    endfunction

endpackage

// File: rtl/tft_cmd_emitter.sv
// Serialises one command byte followed by four parameter bytes
// (0x00, 0x00, param[15:8], param[7:0]) over a valid/ready handshake.
// While en_i is high the current word is presented; last_o marks the
// cycle in which the final parameter byte is accepted.
module tft_cmd_emitter
    import tft_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [7:0]  cmd_i,
    input  logic [15:0] param_i,
    input  logic        wr_rdy_i,
    output logic        wr_vld_o,
    output logic        wr_cmd_o,
    output logic [23:0] wr_data_o,
    output logic        last_o
);

    logic [2:0] idx_q, idx_d;

    // Word selection by index and advance on each accepted word.
    always_comb begin
        idx_d     = idx_q;
        wr_vld_o  = en_i;
        wr_cmd_o  = 1'b0;
        wr_data_o = 24'h000000;
        last_o    = 1'b0;
        if (en_i) begin
            case (idx_q)
                3'd0: begin
                    wr_cmd_o  = 1'b1;
                    wr_data_o = byte_word(cmd_i);
                end
                3'd3:    wr_data_o = byte_word(param_i[15:8]);
                3'd4:    wr_data_o = byte_word(param_i[7:0]);
                default: wr_data_o = 24'h000000;
            endcase
            if (wr_rdy_i) begin
                if (idx_q == 3'd4) begin
                    idx_d  = 3'd0;
                    last_o = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
        end else begin
            idx_d = 3'd0;
        end
    end

    // Word index register.
    always_ff @(posedge clk) begin
        if (rst) idx_q <= 3'd0;
        else     idx_q <= idx_d;
    end

endmodule

// File: rtl/tft_frame_sequencer.sv
// Frame sequencer for a TFT panel: issues CASET/PASET/RAMWR, then pulls one
// pixel at a time from a pixel reader and forwards it to the TFT writer.
module tft_frame_sequencer
    import tft_pkg::*;
#(
    parameter int unsigned FRAME_GAP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [15:0] i_width,
    input  logic [15:0] i_height,
    input  logic        i_pixel_rdy,
    output logic        o_pixel_stb,
    input  logic [7:0]  i_red,
    input  logic [7:0]  i_green,
    input  logic [7:0]  i_blue,
    output logic        o_wr_vld,
    output logic        o_wr_cmd,
    output logic [23:0] o_wr_data,
    input  logic        i_wr_rdy,
    output logic        o_busy,
    output logic        o_frame_done
);

    state_t      state_q, state_d;
    logic [15:0] w_q, w_d, h_q, h_d;
    logic [31:0] n_q, n_d, cnt_q, cnt_d, gap_q, gap_d;
    logic [23:0] pix_q, pix_d;

    logic        em_en, em_vld, em_cmd, em_last;
    logic [7:0]  em_opcode;
    logic [15:0] em_param;
    logic [23:0] em_data;

    // The emitter is shared between CASET and PASET; only opcode and extent differ.
    assign em_en     = (state_q == ST_CASET) || (state_q == ST_PASET);
    assign em_opcode = (state_q == ST_PASET) ? CMD_PASET : CMD_CASET;
    assign em_param  = (state_q == ST_PASET) ? (h_q - 16'd1) : (w_q - 16'd1);

    tft_cmd_emitter u_emitter (
        .clk       (clk),
        .rst       (rst),
        .en_i      (em_en),
        .cmd_i     (em_opcode),
        .param_i   (em_param),
        .wr_rdy_i  (i_wr_rdy),
        .wr_vld_o  (em_vld),
        .wr_cmd_o  (em_cmd),
        .wr_data_o (em_data),
        .last_o    (em_last)
    );

    // Next-state and output decode; outputs depend only on registered state
    // plus the handshake inputs, so reset clears them on the next edge.
    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        h_d          = h_q;
        n_d          = n_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        pix_d        = pix_q;
        o_pixel_stb  = 1'b0;
        o_wr_vld     = em_vld;
        o_wr_cmd     = em_cmd;
        o_wr_data    = em_data;
        o_busy       = (state_q != ST_IDLE) && (state_q != ST_GAP);
        o_frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    w_d   = i_width;
                    h_d   = i_height;
                    n_d   = 32'(i_width) * 32'(i_height);
                    cnt_d = 32'd0;
                    if ((i_width == 16'd0) || (i_height == 16'd0)) state_d = ST_DONE;
                    else                                          state_d = ST_CASET;
                end
            end
            ST_CASET: if (em_last) state_d = ST_PASET;
            ST_PASET: if (em_last) state_d = ST_RAMWR;
            ST_RAMWR: begin
                o_wr_vld  = 1'b1;
                o_wr_cmd  = 1'b1;
                o_wr_data = byte_word(CMD_RAMWR);
                if (i_wr_rdy) begin
                    cnt_d   = 32'd0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (i_pixel_rdy) begin
                    o_pixel_stb = 1'b1;
                    state_d     = ST_LATCH;
                end
            end
            ST_LATCH: begin
                pix_d   = {i_red, i_green, i_blue};
                state_d = ST_SEND;
            end
            ST_SEND: begin
                o_wr_vld  = 1'b1;
                o_wr_cmd  = 1'b0;
                o_wr_data = pix_q;
                if (i_wr_rdy) begin
                    cnt_d = cnt_q + 32'd1;
                    if ((cnt_q + 32'd1) == n_q) state_d = ST_DONE;
                    else                        state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                o_frame_done = 1'b1;
                gap_d        = 32'd0;
                state_d      = (FRAME_GAP > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_q == 32'(FRAME_GAP - 1)) state_d = ST_IDLE;
                else                             gap_d   = gap_q + 32'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            w_q     <= 16'd0;
            h_q     <= 16'd0;
            n_q     <= 32'd0;
            cnt_q   <= 32'd0;
            gap_q   <= 32'd0;
            pix_q   <= 24'h000000;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pix_q   <= pix_d;
        end
    end

endmodule

// File: tb/tb_tft_frame_sequencer.sv
// Scoreboard bench for tft_frame_sequencer: expected words are queued when a
// frame is launched and compared against the words the DUT hands over.
module tb_tft_frame_sequencer;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [15:0] i_width = 16'd0;
    logic [15:0] i_height = 16'd0;
    logic        i_pixel_rdy = 1'b1;
    logic        o_pixel_stb;
    logic [7:0]  i_red = 8'd0;
    logic [7:0]  i_green = 8'd0;
    logic [7:0]  i_blue = 8'd0;
    logic        o_wr_vld;
    logic        o_wr_cmd;
    logic [23:0] o_wr_data;
    logic        i_wr_rdy = 1'b1;
    logic        o_busy;
    logic        o_frame_done;

    always #5 clk = ~clk;

    tft_frame_sequencer #(.FRAME_GAP(GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .i_width      (i_width),
        .i_height     (i_height),
        .i_pixel_rdy  (i_pixel_rdy),
        .o_pixel_stb  (o_pixel_stb),
        .i_red        (i_red),
        .i_green      (i_green),
        .i_blue       (i_blue),
        .o_wr_vld     (o_wr_vld),
        .o_wr_cmd     (o_wr_cmd),
        .o_wr_data    (o_wr_data),
        .i_wr_rdy     (i_wr_rdy),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [24:0] exp_q[$];
    logic [24:0] obs_q[$];
    int          stb_cnt = 0;
    int          done_cnt = 0;
    int          vld_cnt = 0;
    int          hold_err = 0;
    logic        prev_pend = 1'b0;
    logic [24:0] prev_word = 25'd0;

    // Pixel reader model output for the i-th strobe of the run.
    function automatic logic [23:0] pix(input int i);
        logic [7:0] a, b, c;
        a = 8'(i * 7 + 3);
        b = 8'(i) ^ 8'h5A;
        c = 8'(255 - i);
        return {a, b, c};
    endfunction

    // Monitor: records accepted words, strobes, done pulses and hold violations;
    // also plays the pixel reader by presenting a new colour after each strobe.
    always @(negedge clk) begin
        if (prev_pend && !(o_wr_vld && ({o_wr_cmd, o_wr_data} == prev_word)))
            hold_err <= hold_err + 1;
        prev_pend <= o_wr_vld && !i_wr_rdy && !rst;
        prev_word <= {o_wr_cmd, o_wr_data};
        if (o_wr_vld && i_wr_rdy && !rst) obs_q.push_back({o_wr_cmd, o_wr_data});
        if (o_wr_vld) vld_cnt <= vld_cnt + 1;
        if (o_pixel_stb) begin
            {i_red, i_green, i_blue} <= pix(stb_cnt);
            stb_cnt <= stb_cnt + 1;
        end
        if (o_frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic push_header(input logic [15:0] w, input logic [15:0] h);
        logic [15:0] wm, hm;
        wm = w - 16'd1;
        hm = h - 16'd1;
        exp_q.push_back({1'b1, 24'h00002A});
        exp_q.push_back({1'b0, 24'h000000});
        exp_q.push_back({1'b0, 24'h000000});
        exp_q.push_back({1'b0, 16'h0000, wm[15:8]});
        exp_q.push_back({1'b0, 16'h0000, wm[7:0]});
        exp_q.push_back({1'b1, 24'h00002B});
        exp_q.push_back({1'b0, 24'h000000});
        exp_q.push_back({1'b0, 24'h000000});
        exp_q.push_back({1'b0, 16'h0000, hm[15:8]});
        exp_q.push_back({1'b0, 16'h0000, hm[7:0]});
        exp_q.push_back({1'b1, 24'h00002C});
    endtask

    // Runs one frame. mode 0: plain; 1: i_wr_rdy toggles every 3 cycles;
    // 2: i_pixel_rdy held low for 10 cycles in FETCH; 3: i_enable dropped during pixel 1.
    task automatic run_frame(input logic [15:0] w, input logic [15:0] h,
                             input int mode, input string name);
        int n, base_stb, base_done, base_vld, base_hold, cyc, stall, stall_err;
        logic [24:0] e, o;
        exp_q.delete();
        obs_q.delete();
        n = int'(w) * int'(h);
        base_stb  = stb_cnt;
        base_done = done_cnt;
        base_vld  = vld_cnt;
        base_hold = hold_err;
        if (n != 0) begin
            push_header(w, h);
            for (int k = 0; k < n; k++) exp_q.push_back({1'b0, pix(base_stb + k)});
        end
        i_width     = w;
        i_height    = h;
        i_pixel_rdy = (mode != 2);
        i_wr_rdy    = 1'b1;
        i_enable    = 1'b1;
        cyc = 0; stall = 0; stall_err = 0;
        while (done_cnt == base_done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (mode == 1) i_wr_rdy = (((cyc / 3) % 2) == 0);
            if (mode == 3) begin
                if (stb_cnt > base_stb) i_enable = 1'b0;
            end else if (o_busy) begin
                i_enable = 1'b0;
            end
            if (mode == 2 && !i_pixel_rdy && obs_q.size() >= 11) begin
                if (o_pixel_stb || o_wr_vld) stall_err++;
                stall++;
                if (stall >= 10) i_pixel_rdy = 1'b1;
            end
        end
        i_enable = 1'b0;
        i_wr_rdy = 1'b1;
        i_pixel_rdy = 1'b1;
        tests_run++;
        if (done_cnt == base_done) begin
            tests_failed++;
            $display("FAIL %s timeout: no done pulse after %0d cycles, required one", name, cyc);
        end
        repeat (GAP + 6) begin @(posedge clk); #1; end
        tests_run++;
        if (done_cnt - base_done !== 1) begin
            tests_failed++;
            $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt - base_done);
        end
        tests_run++;
        if (stb_cnt - base_stb !== n) begin
            tests_failed++;
            $display("FAIL %s strobes: got %0d, required %0d", name, stb_cnt - base_stb, n);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL %s word_missing: got none, required %h", name, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL %s word: got cmd=%b data=%h, required cmd=%b data=%h",
                             name, o[24], o[23:0], e[24], e[23:0]);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s extra_words: got %0d extra, required 0", name, obs_q.size());
        end
        tests_run++;
        if (hold_err - base_hold !== 0) begin
            tests_failed++;
            $display("FAIL %s hold_stability: got %0d violations, required 0", name, hold_err - base_hold);
        end
        if (n == 0) begin
            tests_run++;
            if (vld_cnt - base_vld !== 0) begin
                tests_failed++;
                $display("FAIL %s zero_size_vld: got %0d valid cycles, required 0", name, vld_cnt - base_vld);
            end
        end
        if (mode == 2) begin
            tests_run++;
            if (stall_err !== 0 || stall !== 10) begin
                tests_failed++;
                $display("FAIL %s fetch_stall: got %0d bad cycles over %0d, required 0 over 10", name, stall_err, stall);
            end
        end
        tests_run++;
        if (o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s busy_after: got %b, required 0", name, o_busy);
        end
        $display("[TB] frame %s %0dx%0d mode %0d checked", name, w, h, mode);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        tests_run++;
        if ({o_pixel_stb, o_wr_vld, o_wr_cmd, o_busy, o_frame_done} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got stb/vld/cmd/busy/done=%b, required 00000",
                     {o_pixel_stb, o_wr_vld, o_wr_cmd, o_busy, o_frame_done});
        end
        tests_run++;
        if (o_wr_data !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h, required 000000", o_wr_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        run_frame(16'd2, 16'd2, 0, "basic_2x2");
    endtask

    task automatic test_backpressure();
        run_frame(16'd3, 16'd2, 1, "backpressure_3x2");
    endtask

    task automatic test_zero_size();
        run_frame(16'd320, 16'd0, 0, "zero_320x0");
    endtask

    task automatic test_reset_mid_frame();
        int cyc, base_done;
        obs_q.delete();
        base_done = done_cnt;
        i_width = 16'd4;
        i_height = 16'd4;
        i_enable = 1'b1;
        cyc = 0;
        while (obs_q.size() < 13 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            if (o_busy) i_enable = 1'b0;
        end
        i_enable = 1'b0;
        tests_run++;
        if (obs_q.size() < 13) begin
            tests_failed++;
            $display("FAIL midrst_progress: got %0d words, required 13", obs_q.size());
        end
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({o_pixel_stb, o_wr_vld, o_wr_cmd, o_busy, o_frame_done} !== 5'b0 || o_wr_data !== 24'h0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got flags=%b data=%h, required 00000 and 000000",
                     {o_pixel_stb, o_wr_vld, o_wr_cmd, o_busy, o_frame_done}, o_wr_data);
        end
        rst = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        tests_run++;
        if (done_cnt !== base_done) begin
            tests_failed++;
            $display("FAIL midrst_no_done: got %0d pulses, required 0", done_cnt - base_done);
        end
        $display("[TB] reset mid-frame checked");
        run_frame(16'd1, 16'd1, 0, "after_reset_1x1");
    endtask

    task automatic test_enable_drop();
        run_frame(16'd2, 16'd2, 3, "enable_drop_2x2");
    endtask

    task automatic test_pixel_stall();
        run_frame(16'd2, 16'd1, 2, "pixel_stall_2x1");
    endtask

    task automatic test_back_to_back();
        run_frame(16'd1, 16'd3, 0, "b2b_a_1x3");
        run_frame(16'd3, 16'd1, 1, "b2b_b_3x1");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_size();
        test_reset_mid_frame();
        test_enable_drop();
        test_pixel_stall();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tft_frame_sequencer.md
TFT_FRAME_SEQUENCER -- requirements
Module: tft_frame_sequencer

Interface
REQ-001 Parameter FRAME_GAP, default 0, idle clk cycles inserted between frames, from DONE to the next CASET.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_enable  input  1  level; frames are issued while high.
REQ-005 i_width  input  16  frame columns; sampled at frame start.
REQ-006 i_height  input  16  frame rows; sampled at frame start.
REQ-007 i_pixel_rdy  input  1  pixel_reader has a pixel available.
REQ-008 o_pixel_stb  output  1  one-cycle pixel pull strobe to pixel_reader.
REQ-009 i_red, i_green, i_blue  input  8 each  pixel_reader colour outputs.
REQ-010 o_wr_vld  output  1  write word valid toward TFT writer.
REQ-011 o_wr_cmd  output  1  1 = command byte, 0 = parameter/pixel data.
REQ-012 o_wr_data  output  24  [7:0] = command/parameter byte with [23:8] = 0; or pixel {R,G,B}.
REQ-013 i_wr_rdy  input  1  TFT writer accepts the word when o_wr_vld && i_wr_rdy.
REQ-014 o_busy  output  1  high from CASET entry until DONE exit.
REQ-015 o_frame_done  output  1  one-cycle pulse per completed or skipped frame.

Function
REQ-016 States SHALL be IDLE, CASET, PASET, RAMWR, FETCH, LATCH, SEND, DONE, GAP.
REQ-017 IDLE with i_enable=1: latch W=i_width, H=i_height; compute N=W*H as 32-bit unsigned; go to CASET, or to DONE if W=0 or H=0, with no writes issued.
REQ-018 CASET SHALL emit 5 words in order: cmd 0x2A, then data 0x00, 0x00, (W-1)[15:8], (W-1)[7:0].
REQ-019 PASET SHALL emit cmd 0x2B, then data 0x00, 0x00, (H-1)[15:8], (H-1)[7:0].
REQ-020 RAMWR SHALL emit cmd 0x2C once, then go to FETCH with pixel counter = 0.
REQ-021 Each word: o_wr_vld/o_wr_cmd/o_wr_data held stable until accepted; next word is presented no earlier than the cycle after acceptance.
REQ-022 FETCH: when i_pixel_rdy=1, pulse o_pixel_stb for exactly one cycle and go to LATCH; otherwise wait with o_pixel_stb=0.
REQ-023 LATCH: capture {i_red,i_green,i_blue} in the cycle following the strobe; go to SEND.
REQ-024 SEND: present the captured pixel with o_wr_cmd=0 until accepted; then increment the counter; go to DONE if counter = N, else to FETCH.
REQ-025 o_pixel_stb SHALL never be asserted outside FETCH; at most one strobe is outstanding per pixel.
REQ-026 DONE: pulse o_frame_done one cycle, then go to GAP if FRAME_GAP>0, else to IDLE.
REQ-027 GAP: count FRAME_GAP cycles, then go to IDLE.
REQ-028 Deasserting i_enable mid-frame SHALL NOT abort; the frame completes, and no new frame starts while i_enable=0.
REQ-029 i_width/i_height changes during a frame SHALL be ignored until the next IDLE sample.
REQ-030 Maximum N = 65535*65535; the 32-bit counter SHALL not wrap.

Reset
REQ-031 On rst: state=IDLE; counter=0; o_pixel_stb, o_wr_vld, o_wr_cmd, o_busy, o_frame_done = 0; o_wr_data = 0.
REQ-032 rst asserted mid-frame SHALL abandon the frame at the next edge with no o_frame_done pulse; the next frame restarts at CASET.

Structure
REQ-033 Shared package tft_pkg SHALL hold state encoding and constants CMD_CASET=0x2A, CMD_PASET=0x2B, CMD_RAMWR=0x2C.
REQ-034 One sub-module, tft_cmd_emitter, SHALL serialise the command byte plus 4 parameter bytes over the o_wr_* handshake for CASET and PASET.

Verification
REQ-035 W=2, H=2, i_wr_rdy=1, i_pixel_rdy=1 -> 11 words 2A,00,00,00,01,2B,00,00,00,01,2C (cmd flags 1,0,0,0,0,1,0,0,0,0,1); then 4 pixel words matching reader data in order; exactly 4 strobes; one o_frame_done pulse.
REQ-036 i_wr_rdy toggling every 3 cycles -> o_wr_data/o_wr_cmd stable while o_wr_vld=1 and unaccepted; no word dropped or duplicated.
REQ-037 W=320, H=0 -> no o_wr_vld, no o_pixel_stb; o_frame_done pulses once.
REQ-038 rst asserted after the 2nd pixel of a 4x4 frame -> all outputs 0 next cycle; no done pulse; next frame restarts at 0x2A.
REQ-039 i_enable dropped during pixel 1 of 2x2 with FRAME_GAP=4 -> all 4 pixels sent, done pulse, no new CASET.
REQ-040 i_pixel_rdy held low 10 cycles in FETCH -> no strobe, o_wr_vld=0; resumes correctly when i_pixel_rdy rises.
